// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: operand/count widths,
// shift mode and direction codes, and the sequencer FSM state encoding.
package shift_pkg;

    localparam int WIDTH_C = 8;
    localparam int AMT_W_C = 3;

    // Shift mode codes; the reserved code behaves as a logical shift.
    typedef enum logic [1:0] {
        MODE_LOGICAL = 2'b00,
        MODE_ARITH   = 2'b01,
        MODE_ROTATE  = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    // Shift direction codes.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for the shift sequencer.
// The master issues requests and consumes results; the slave is the sequencer.
interface shift_sequencer_if;
    import shift_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH_C-1:0]   in_data;
    logic [AMT_W_C-1:0]   in_amount;
    logic                 in_dir;
    logic [1:0]           in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH_C-1:0]   out_data;
    logic                 out_carry;
    logic                 busy;

    modport master (
        output in_valid, in_data, in_amount, in_dir, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_carry, busy
    );

    modport slave (
        input  in_valid, in_data, in_amount, in_dir, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_carry, busy
    );

endinterface

// File: rtl/shift_step_8.sv
// Single 1-bit shift step on an 8-bit operand. Pure combinational:
// produces the next operand value and the bit that falls off the end.
module shift_step_8
    import shift_pkg::*;
(
    input  logic [7:0] i_data,
    input  dir_e       i_dir,
    input  mode_e      i_mode,
    output logic [7:0] o_data,
    output logic       o_bit
);

    logic w_fill;

    // Select the fill bit for the vacated position and form the shifted value.
    always_comb begin
        w_fill = 1'b0;
        o_data = i_data;
        o_bit  = 1'b0;
        if (i_dir == DIR_LEFT) begin
            // Arithmetic left is identical to logical left (zero fill).
            case (i_mode)
                MODE_ROTATE: w_fill = i_data[7];
                default:     w_fill = 1'b0;
            endcase
            o_data = {i_data[6:0], w_fill};
            o_bit  = i_data[7];
        end else begin
            case (i_mode)
                MODE_ARITH:  w_fill = i_data[7];
                MODE_ROTATE: w_fill = i_data[0];
                default:     w_fill = 1'b0;
            endcase
            o_data = {w_fill, i_data[7:1]};
            o_bit  = i_data[0];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: accepts one request, performs N single-bit steps
// (one per clock), then presents the result until it is consumed.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_sequencer_if.slave bus
);

    localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
    localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    state_e             r_state;
    logic [WIDTH-1:0]   r_data;
    logic               r_carry;
    dir_e               r_dir;
    mode_e              r_mode;
    logic [AMT_W-1:0]   r_count;
    logic               r_idle;
    logic               r_out_valid;
    logic               r_busy;

    logic [WIDTH-1:0]   w_step_data;
    logic               w_step_bit;
    logic               w_accept;

    // in_ready is gated by rst_n so it drops the instant reset is asserted.
    assign bus.in_ready  = r_idle & rst_n;
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.out_data  = r_data;
    assign bus.out_carry = r_carry;

    shift_step_8 u_step (
        .i_data (r_data),
        .i_dir  (r_dir),
        .i_mode (r_mode),
        .o_data (w_step_data),
        .o_bit  (w_step_bit)
    );

    // Sequencer FSM: accept, step once per clock, hold result until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_data      <= {WIDTH{1'b0}};
            r_carry     <= 1'b0;
            r_dir       <= DIR_LEFT;
            r_mode      <= MODE_LOGICAL;
            r_count     <= CNT_ZERO;
            r_idle      <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Request fields are sampled only on the accept edge.
                    if (w_accept) begin
                        r_data  <= bus.in_data;
                        r_dir   <= dir_e'(bus.in_dir);
                        r_mode  <= mode_e'(bus.in_mode);
                        r_count <= bus.in_amount;
                        r_carry <= 1'b0;
                        r_idle  <= 1'b0;
                        r_busy  <= 1'b1;
                        if (bus.in_amount == CNT_ZERO) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_data  <= w_step_data;
                    r_carry <= w_step_bit;
                    r_count <= r_count - CNT_ONE;
                    // The last step lands the result and raises out_valid together.
                    if (r_count == CNT_ONE) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Result registers are untouched here, so they stay stable
                    // through the hold and remain visible afterwards in IDLE.
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_idle      <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_count     <= CNT_ZERO;
                    r_idle      <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vectors plus randomized
// requests compared against an arithmetic reference model.
module tb_shift_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    shift_sequencer_if bus();

    shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole N-bit shift computed in one go with integer arithmetic.
    function automatic void ref_shift(input logic [7:0] d, input int n,
                                      input logic dir, input logic [1:0] mode,
                                      output logic [7:0] res, output logic carry);
        int v;
        int r;
        v = int'(d);
        if (n == 0) begin
            r = v;
            carry = 1'b0;
        end else if (dir == 1'b0) begin
            if (mode == 2'b10) r = ((v << n) | (v >> (8 - n))) & 255;
            else               r = (v << n) & 255;
            carry = 1'(((v >> (8 - n)) & 1));
        end else begin
            if (mode == 2'b01)      r = (int'($signed(d)) >>> n) & 255;
            else if (mode == 2'b10) r = ((v >> n) | (v << (8 - n))) & 255;
            else                    r = v >> n;
            carry = 1'(((v >> (n - 1)) & 1));
        end
        res = 8'(r);
    endfunction

    task automatic drive_garbage();
        bus.in_data   = 8'($urandom);
        bus.in_amount = 3'($urandom);
        bus.in_dir    = 1'($urandom);
        bus.in_mode   = 2'($urandom);
    endtask

    // Issue one request at a negedge; return at the negedge where out_valid is seen.
    task automatic start_op(input logic [7:0] d, input int n, input logic dir,
                            input logic [1:0] mode, output logic [7:0] o_d,
                            output logic o_c, output int lat, output logic acc_ok);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_amount = 3'(n);
        bus.in_dir    = dir;
        bus.in_mode   = mode;
        bus.out_ready = 1'b0;
        acc_ok = bus.in_ready;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        bus.in_valid = 1'($urandom_range(0, 1));
        drive_garbage();
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            drive_garbage();
        end
        bus.in_valid = 1'b0;
        o_d = bus.out_data;
        o_c = bus.out_carry;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive_garbage();
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b0)    begin bad++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        total++; if (bus.out_data !== 8'h00)   begin bad++; $display("FAIL reset_out_data got %h want 00", bus.out_data); end
        total++; if (bus.out_carry !== 1'b0)   begin bad++; $display("FAIL reset_out_carry got %b want 0", bus.out_carry); end
        rst_n = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1)    begin bad++; $display("FAIL release_in_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [7:0] vd [3] = '{8'hB4, 8'h81, 8'h01};
        int         vn [3] = '{3, 2, 7};
        logic       vdir [3] = '{1'b0, 1'b1, 1'b1};
        logic [1:0] vm [3] = '{2'b00, 2'b01, 2'b10};
        logic [7:0] ed [3] = '{8'hA0, 8'hE0, 8'h02};
        logic       ec [3] = '{1'b1, 1'b0, 1'b0};
        logic [7:0] od;
        logic oc, acc;
        int lat;
        for (int i = 0; i < 3; i++) begin
            start_op(vd[i], vn[i], vdir[i], vm[i], od, oc, lat, acc);
            total++; if (acc !== 1'b1)   begin bad++; $display("FAIL vec%0d_ready got %b want 1", i, acc); end
            total++; if (od !== ed[i])   begin bad++; $display("FAIL vec%0d_data got %h want %h", i, od, ed[i]); end
            total++; if (oc !== ec[i])   begin bad++; $display("FAIL vec%0d_carry got %b want %b", i, oc, ec[i]); end
            total++; if (lat != vn[i])   begin bad++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, vn[i]); end
            consume();
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL vec%0d_ready_after got %b want 1", i, bus.in_ready); end
        end
    endtask

    task automatic test_zero_hold();
        logic [7:0] od;
        logic oc, acc;
        int lat;
        start_op(8'h5A, 0, 1'($urandom), 2'($urandom), od, oc, lat, acc);
        total++; if (lat != 0) begin bad++; $display("FAIL zero_latency got %0d want 0", lat); end
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.out_valid !== 1'b1)  begin bad++; $display("FAIL zero_hold_valid got %b want 1", bus.out_valid); end
            total++; if (bus.out_data !== 8'h5A)  begin bad++; $display("FAIL zero_hold_data got %h want 5a", bus.out_data); end
            total++; if (bus.out_carry !== 1'b0)  begin bad++; $display("FAIL zero_hold_carry got %b want 0", bus.out_carry); end
            total++; if (bus.in_ready !== 1'b0)   begin bad++; $display("FAIL zero_hold_ready got %b want 0", bus.in_ready); end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL consume_cycle_ready got %b want 0", bus.in_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        total++; if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL after_consume_ready got %b want 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL after_consume_valid got %b want 0", bus.out_valid); end
        @(negedge clk);
        total++; if (bus.out_data !== 8'h5A) begin bad++; $display("FAIL idle_retain_data got %h want 5a", bus.out_data); end
    endtask

    task automatic test_reset_mid_shift();
        logic [7:0] od;
        logic oc, acc;
        int lat;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h3C;
        bus.in_amount = 3'd5;
        bus.in_dir    = 1'b0;
        bus.in_mode   = 2'b00;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        total++; if (bus.busy !== 1'b1)      begin bad++; $display("FAIL mid_shift_busy got %b want 1", bus.busy); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_shift_valid got %b want 0", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL rst_mid_data got %h want 00", bus.out_data); end
        total++; if (bus.out_carry !== 1'b0) begin bad++; $display("FAIL rst_mid_carry got %b want 0", bus.out_carry); end
        total++; if (bus.busy !== 1'b0)      begin bad++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
        total++; if (bus.in_ready !== 1'b0)  begin bad++; $display("FAIL rst_mid_ready got %b want 0", bus.in_ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got %b want 1", bus.in_ready); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL discarded_valid got %b want 0", bus.out_valid); end
        end
        start_op(8'hFF, 4, 1'b1, 2'b11, od, oc, lat, acc);
        total++; if (od !== 8'h0F) begin bad++; $display("FAIL post_rst_data got %h want 0f", od); end
        total++; if (oc !== 1'b1)  begin bad++; $display("FAIL post_rst_carry got %b want 1", oc); end
        total++; if (lat != 4)     begin bad++; $display("FAIL post_rst_latency got %0d want 4", lat); end
        consume();
    endtask

    task automatic test_random();
        logic [7:0] d, od, ed;
        logic dir, oc, ec, acc;
        logic [1:0] m;
        int n, lat, hold;
        for (int i = 0; i < 40; i++) begin
            d    = 8'($urandom);
            n    = $urandom_range(0, 7);
            dir  = 1'($urandom);
            m    = 2'($urandom);
            hold = $urandom_range(0, 2);
            ref_shift(d, n, dir, m, ed, ec);
            start_op(d, n, dir, m, od, oc, lat, acc);
            total++; if (acc !== 1'b1) begin bad++; $display("FAIL rnd%0d_ready got %b want 1", i, acc); end
            total++; if (od !== ed)    begin bad++; $display("FAIL rnd%0d_data d=%h n=%0d dir=%b m=%b got %h want %h", i, d, n, dir, m, od, ed); end
            total++; if (oc !== ec)    begin bad++; $display("FAIL rnd%0d_carry d=%h n=%0d dir=%b m=%b got %b want %b", i, d, n, dir, m, oc, ec); end
            total++; if (lat != n)     begin bad++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, n); end
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                total++; if (bus.out_data !== ed || bus.out_valid !== 1'b1) begin
                    bad++; $display("FAIL rnd%0d_hold got %h/%b want %h/1", i, bus.out_data, bus.out_valid, ed);
                end
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, od, ed;
        logic oc, ec, acc;
        int n, lat;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            n = $urandom_range(1, 7);
            ref_shift(d, n, 1'b0, 2'b10, ed, ec);
            start_op(d, n, 1'b0, 2'b10, od, oc, lat, acc);
            total++; if (acc !== 1'b1) begin bad++; $display("FAIL b2b%0d_ready got %b want 1", i, acc); end
            total++; if (od !== ed || oc !== ec) begin
                bad++; $display("FAIL b2b%0d_result got %h/%b want %h/%b", i, od, oc, ed, ec);
            end
            consume();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_vectors();
        test_zero_hold();
        test_reset_mid_shift();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
